// File: rtl/regfile_wb_queue_pkg.sv
// wbq_pkg: shared widths, helper functions and entry type for the write-back queue
package wbq_pkg;

    localparam int WBQ_WIDTH = 16;
    localparam int WBQ_DEPTH = 8;

    function automatic int wbq_ptr_w(input int qdepth);
        return $clog2(qdepth);
    endfunction

    function automatic int wbq_cnt_w(input int qdepth);
        return $clog2(qdepth + 1);
    endfunction

    typedef struct packed {
        logic                         valid;
        logic [$clog2(WBQ_DEPTH)-1:0] reg_idx;
        logic [WBQ_WIDTH-1:0]         data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: request, write-port, forwarding and occupancy signals of the write-back queue
interface regfile_wb_queue_if
    import wbq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int QDEPTH = 4
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic [$clog2(DEPTH)-1:0]       in_reg;
    logic [WIDTH-1:0]               in_data;
    logic                           wb_stall;
    logic                           wb_we;
    logic [$clog2(DEPTH)-1:0]       wb_reg;
    logic [WIDTH-1:0]               wb_data;
    logic [$clog2(DEPTH)-1:0]       fwd_reg1;
    logic [$clog2(DEPTH)-1:0]       fwd_reg2;
    logic                           fwd_hit1;
    logic                           fwd_hit2;
    logic [WIDTH-1:0]               fwd_data1;
    logic [WIDTH-1:0]               fwd_data2;
    logic [wbq_cnt_w(QDEPTH)-1:0]   count;

    modport master (
        output in_valid, in_reg, in_data, wb_stall, fwd_reg1, fwd_reg2,
        input  in_ready, wb_we, wb_reg, wb_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, wb_stall, fwd_reg1, fwd_reg2,
        output in_ready, wb_we, wb_reg, wb_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );

endinterface

// File: rtl/regfile_wb_queue_match.sv
// wbq_match: newest-first search of the queue entries for a register index
module wbq_match
    import wbq_pkg::*;
#(
    parameter type entry_t = wbq_entry_t,
    parameter int  QDEPTH  = 4,
    parameter int  IW      = 3,
    parameter int  WIDTH   = 16
) (
    input  entry_t                       ent [QDEPTH],
    input  logic [wbq_ptr_w(QDEPTH)-1:0] tail,
    input  logic [IW-1:0]                idx,
    output logic                         hit,
    output logic [WIDTH-1:0]             data
);

    localparam int PW = wbq_ptr_w(QDEPTH);

    // walk from the slot at tail (oldest position) around to tail-1 so the newest match wins
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent[tail + PW'(i)].valid && ent[tail + PW'(i)].reg_idx == idx) begin
                hit  = 1'b1;
                data = ent[tail + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back queue ahead of the register file write port; forwarding enabled by WBQ_FWD_EN
module regfile_wb_queue
    import wbq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int QDEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_queue_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = wbq_ptr_w(QDEPTH);
    localparam int CW = wbq_cnt_w(QDEPTH);

    typedef struct packed {
        logic             valid;
        logic [IW-1:0]    reg_idx;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        q [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          enq;
    logic          deq;

    assign bus.in_ready = !rst && (cnt != CW'(QDEPTH));
    assign enq          = bus.in_valid && bus.in_ready;
    assign bus.wb_we    = q[head].valid && !bus.wb_stall;
    assign deq          = bus.wb_we;
    assign bus.wb_reg   = q[head].valid ? q[head].reg_idx : '0;
    assign bus.wb_data  = q[head].valid ? q[head].data : '0;
    assign bus.count    = cnt;

    // circular buffer: write at tail, retire at head; a full queue never enqueues so slots never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else begin
            if (deq) q[head] <= '0;
            if (enq) begin
                q[tail].valid   <= 1'b1;
                q[tail].reg_idx <= bus.in_reg;
                q[tail].data    <= bus.in_data;
            end
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            cnt <= cnt + CW'(enq) - CW'(deq);
        end
    end

`ifdef WBQ_FWD_EN
    wbq_match #(.entry_t(entry_t), .QDEPTH(QDEPTH), .IW(IW), .WIDTH(WIDTH)) u_match1 (
        .ent(q), .tail(tail), .idx(bus.fwd_reg1), .hit(bus.fwd_hit1), .data(bus.fwd_data1)
    );
    wbq_match #(.entry_t(entry_t), .QDEPTH(QDEPTH), .IW(IW), .WIDTH(WIDTH)) u_match2 (
        .ent(q), .tail(tail), .idx(bus.fwd_reg2), .hit(bus.fwd_hit2), .data(bus.fwd_data2)
    );
`else
    logic unused_fwd;
    assign unused_fwd    = ^{bus.fwd_reg1, bus.fwd_reg2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue in front of the register file write port. Accepts register write requests from the execute/memory stages with a valid/ready handshake, buffers them in order, and drains at most one per cycle into the register file's `we`/`write_reg`/`write_data` port. Exposes two forwarding lookups, aligned with the register file's two read ports, so readers see pending writes before they land.

## Interface

**Parameters**
- `WIDTH`, 16: data width; matches the register file.
- `DEPTH`, 8: number of architectural registers; register index is `$clog2(DEPTH)` bits.
- `QDEPTH`, 4: queue entries; power of two, at least 2.

**Ports**
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: write request valid.
- `in_ready`, out, 1: queue can accept.
- `in_reg`, in, `$clog2(DEPTH)`: destination register.
- `in_data`, in, `WIDTH`: write data.
- `wb_stall`, in, 1: write port unavailable this cycle.
- `wb_we`, out, 1: to register file `we`.
- `wb_reg`, out, `$clog2(DEPTH)`: to register file `write_reg`.
- `wb_data`, out, `WIDTH`: to register file `write_data`.
- `fwd_reg1`, `fwd_reg2`, in, `$clog2(DEPTH)`: lookup indices, same as `read_reg1`/`read_reg2`.
- `fwd_hit1`, `fwd_hit2`, out, 1: a pending write to the index exists.
- `fwd_data1`, `fwd_data2`, out, `WIDTH`: data of the newest matching entry.
- `count`, out, `$clog2(QDEPTH+1)`: occupied entries.

## Operation

- Circular buffer with head/tail pointers of `$clog2(QDEPTH)` bits. Pointers wrap from `QDEPTH-1` to 0. A per-entry valid bit holds `reg` and `data`.
- Enqueue happens when `in_valid && in_ready` at the clock edge. The entry is written at the tail, the tail advances, and the valid bit is set.
- `in_ready = !rst && (count != QDEPTH)`. When full, there is no enqueue even if a drain occurs in the same cycle.
- Drain: `wb_we = (count != 0) && !wb_stall`. `wb_reg` and `wb_data` show the head entry whenever `count != 0`, and are 0 when empty. On an edge with `wb_we` high, the head is cleared and advances.
- Simultaneous enqueue and drain: `count` is unchanged, both pointers advance, and ordering is preserved.
- Writes leave in strict acceptance order. Duplicate destinations are kept as separate entries, so the register file sees every write and the last write wins.
- Forwarding is combinational over the valid entries.
  - The hit is reported for the newest entry, i.e. the one closest to the tail, whose `reg` equals `fwd_regN`.
  - The head entry being drained this cycle still counts as pending, because the register file is written only at the edge.
  - A request presented on `in_*` in the same cycle is not forwarded.
  - On a miss, `fwd_dataN` is 0.
- Register index 0 gets no special treatment.

## Timing

- Reset (asynchronous): `count` = 0, pointers = 0, all valid bits = 0. This gives `wb_we` = 0, `wb_reg` = `wb_data` = 0, `fwd_hit*` = 0, `fwd_data*` = 0, and `in_ready` = 0 while `rst` is high. `in_ready` becomes 1 in the first cycle after release.
- Latency: a request accepted at edge N appears at the head in cycle N+1 if the queue was empty. The register file is updated at edge N+1 unless stalled, so the minimum is 2 edges from acceptance to architectural state.
- Forwarding: a hit is visible from cycle N+1 until the cycle in which the entry drains, inclusive.
- Throughput: one enqueue and one drain per cycle.
- `wb_stall` held high freezes the head. The queue fills and `in_ready` drops when `count == QDEPTH`.
- Reset asserted mid-operation discards all pending entries immediately. No `wb_we` pulse occurs during reset.

## Configuration

- `WBQ_FWD_EN` defined: forwarding logic is present as described above.
- `WBQ_FWD_EN` undefined:
  - `fwd_hit1`/`fwd_hit2` are tied to 0 and `fwd_data1`/`fwd_data2` are tied to 0.
  - The ports remain in place, and queue behaviour is unchanged.
  - Readers must interlock on `count != 0`.

## Structure

- Package `wbq_pkg`:
  - function `wbq_ptr_w(QDEPTH)` and function `wbq_cnt_w(QDEPTH)`.
  - typedef `wbq_entry_t` containing `valid`, `reg`, `data`.
- Sub-module `wbq_match`: a priority search, newest-first from the tail, over the entry array. It has one lookup index input and produces hit and data outputs. It is instantiated twice, once per forwarding port, and only when `WBQ_FWD_EN` is defined.

## Test plan

- **Reset:** hold `rst`=1 with `in_valid`=1 → `in_ready`=0, `wb_we`=0, `count`=0. Release → `in_ready`=1.
- **Single write:** enqueue reg 3, data 0x1234, `wb_stall`=0 → next cycle `wb_we`=1, `wb_reg`=3, `wb_data`=0x1234, `fwd_hit1`=1 with `fwd_reg1`=3. Following cycle `count`=0 and `fwd_hit1`=0.
- **Stall to full:** `wb_stall`=1, enqueue 5 requests back-to-back → 4 accepted, `in_ready`=0 on the 5th, `count`=4. Release the stall → drains in order over 4 cycles.
- **Duplicates:** with the queue stalled, enqueue reg 2/0xAAAA then reg 2/0xBBBB → `fwd_data2`=0xBBBB. Drain order is 0xAAAA then 0xBBBB.
- **Wrap-around:** 10 enqueue+drain pairs in consecutive cycles → `count` stays at 1, data order is exact, and the pointers wrap twice without loss.
- **Reset mid-operation:** `count`=3 with stall, assert `rst` between edges → `count`=0 and `fwd_hit*`=0 immediately. After release, no stale writes appear on `wb_we`.
